// File: rtl/hilo_ctrl.sv
// HI/LO controller: routes DIV/DIVU to external dividers and MTHI/MTLO to HI/LO; sets a sticky error on divider timeout.
// Latency: MTHI/MTLO and divide-by-zero write at the accepting edge. A nonzero divide stalls 35 cycles with a 32-cycle divider.
// Backpressure: stall is held from acceptance until capture or timeout. Strobes outside IDLE are dropped, not queued.
// Ports: clock/reset (async, active-high); op_* strobes and rs_val/rt_val from decode;
//        div_dividend/div_divisor and div_start/divu_start go to the dividers; div_busy/divu_busy
//        and div_q/div_r/divu_q/divu_r come back; hi/lo, stall, done and err go to the pipeline.
module hilo_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic        op_div,
    input  logic        op_divu,
    input  logic        op_mthi,
    input  logic        op_mtlo,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    output logic        div_start,
    output logic        divu_start,
    input  logic        div_busy,
    input  logic        divu_busy,
    input  logic [31:0] div_q,
    input  logic [31:0] div_r,
    input  logic [31:0] divu_q,
    input  logic [31:0] divu_r,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stall,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t      state;
    state_t      state_nx;
    logic        sel;        // 0: signed divider, 1: unsigned divider
    logic [5:0]  wd;         // WAIT-cycle watchdog, 0 in the first WAIT cycle
    logic        in_idle;
    logic        any_div;
    logic        rt_zero;
    logic        accept;
    logic        div_zero;
    logic        take_mthi;
    logic        take_mtlo;
    logic        sel_busy;
    logic        capture;
    logic        timeout;

    always_comb begin
        in_idle   = (state == IDLE);
        any_div   = op_div || op_divu;
        rt_zero   = (rt_val == 32'd0);
        accept    = in_idle && any_div && !rt_zero;
        div_zero  = in_idle && any_div && rt_zero;
        take_mthi = in_idle && !any_div && op_mthi;
        take_mtlo = in_idle && !any_div && !op_mthi && op_mtlo;
        sel_busy  = sel ? divu_busy : div_busy;
        // Busy only rises at the edge that ends ISSUE, so the first WAIT cycle
        // (wd == 0) sees a stale busy and must not be trusted.
        capture   = (state == WAIT) && (wd != 6'd0) && !sel_busy;
        // wd == 47 is the 48th WAIT cycle; giving up at its closing edge.
        timeout   = (state == WAIT) && !capture && (wd == 6'd47);
        stall     = !in_idle || accept;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (capture || timeout) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hi           <= 32'd0;
            lo           <= 32'd0;
            div_dividend <= 32'd0;
            div_divisor  <= 32'd0;
            div_start    <= 1'b0;
            divu_start   <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            sel          <= 1'b0;
            wd           <= 6'd0;
        end else begin
            div_start  <= 1'b0;
            divu_start <= 1'b0;
            done       <= 1'b0;

            // Start pulses are registered here so they are high exactly in ISSUE.
            if (accept) begin
                div_dividend <= rs_val;
                div_divisor  <= rt_val;
                sel          <= !op_div;
                div_start    <= op_div;
                divu_start   <= !op_div;
            end

            if (div_zero) begin
                lo   <= 32'hFFFF_FFFF;
                hi   <= rs_val;
                done <= 1'b1;
            end else if (take_mthi) begin
                hi <= rs_val;
            end else if (take_mtlo) begin
                lo <= rs_val;
            end

            if (state == ISSUE)     wd <= 6'd0;
            else if (state == WAIT) wd <= wd + 6'd1;

            if (capture) begin
                lo   <= sel ? divu_q : div_q;
                hi   <= sel ? divu_r : div_r;
                done <= 1'b1;
            end

            if (timeout) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hilo_ctrl.sv
module tb_hilo_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        op_div = 1'b0, op_divu = 1'b0, op_mthi = 1'b0, op_mtlo = 1'b0;
    logic [31:0] rs_val = 32'd0, rt_val = 32'd0;
    logic [31:0] div_dividend, div_divisor;
    logic        div_start, divu_start;
    logic        div_busy = 1'b0, divu_busy = 1'b0;
    logic [31:0] div_q = 32'h1357_9BDF, div_r = 32'h2468_ACE0;
    logic [31:0] divu_q = 32'h0BAD_F00D, divu_r = 32'h0DEA_DBEE;
    logic [31:0] hi, lo;
    logic        stall, done, err;

    hilo_ctrl dut (
        .clock(clock), .reset(reset),
        .op_div(op_div), .op_divu(op_divu), .op_mthi(op_mthi), .op_mtlo(op_mtlo),
        .rs_val(rs_val), .rt_val(rt_val),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_start(div_start), .divu_start(divu_start),
        .div_busy(div_busy), .divu_busy(divu_busy),
        .div_q(div_q), .div_r(div_r), .divu_q(divu_q), .divu_r(divu_r),
        .hi(hi), .lo(lo), .stall(stall), .done(done), .err(err)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clock) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard queues and architectural reference state
    typedef struct { logic [31:0] hi; logic [31:0] lo; } res_t;
    typedef struct { logic usel; logic [31:0] a; logic [31:0] b; int cyc; } st_t;
    res_t        done_q[$];
    st_t         start_q[$];
    int          stall_q[$];
    logic [31:0] ref_hi = 32'd0, ref_lo = 32'd0;
    logic        ref_err = 1'b0;
    logic        hang = 1'b0;

    // Divider models: 32 busy cycles seen by the controller, results only on completion
    int          s_cnt = 0, u_cnt = 0;
    logic [31:0] s_a = 0, s_b = 1, u_a = 0, u_b = 1;

    always @(negedge clock) begin
        if (reset) begin
            div_busy = 1'b0; s_cnt = 0;
        end else if (div_start) begin
            div_busy = 1'b1; s_cnt = 33; s_a = div_dividend; s_b = div_divisor;
            div_q = $urandom; div_r = $urandom;
        end else if (div_busy && !hang) begin
            s_cnt = s_cnt - 1;
            if (s_cnt == 0) begin
                div_busy = 1'b0;
                div_q = $signed(s_a) / $signed(s_b);
                div_r = $signed(s_a) % $signed(s_b);
            end
        end
    end

    always @(negedge clock) begin
        if (reset) begin
            divu_busy = 1'b0; u_cnt = 0;
        end else if (divu_start) begin
            divu_busy = 1'b1; u_cnt = 33; u_a = div_dividend; u_b = div_divisor;
            divu_q = $urandom; divu_r = $urandom;
        end else if (divu_busy && !hang) begin
            u_cnt = u_cnt - 1;
            if (u_cnt == 0) begin
                divu_busy = 1'b0;
                divu_q = u_a / u_b;
                divu_r = u_a % u_b;
            end
        end
    end

    // Monitor: done events, start pulses and stall-run lengths against the queues
    int run = 0;
    always @(negedge clock) begin : monitor
        res_t e;
        st_t  s;
        if (reset) begin
            run = 0;
        end else begin
            if (done) begin
                if (done_q.size() == 0) chk("done_unexpected", {31'd0, done}, 32'd0);
                else begin
                    e = done_q.pop_front();
                    chk("done_hi", hi, e.hi);
                    chk("done_lo", lo, e.lo);
                end
            end
            if (div_start || divu_start) begin
                if (start_q.size() == 0) chk("start_unexpected", {30'd0, div_start, divu_start}, 32'd0);
                else begin
                    s = start_q.pop_front();
                    chk("start_which", {30'd0, div_start, divu_start}, s.usel ? 32'd1 : 32'd2);
                    chk("start_cycle", cyc, s.cyc);
                    chk("start_dividend", div_dividend, s.a);
                    chk("start_divisor", div_divisor, s.b);
                end
            end
            if (stall) run = run + 1;
            else if (run > 0) begin
                if (stall_q.size() == 0) chk("stall_unexpected", run, 32'd0);
                else chk("stall_len", run, stall_q.pop_front());
                run = 0;
            end
        end
    end

    task automatic clear_ops();
        op_div = 1'b0; op_divu = 1'b0; op_mthi = 1'b0; op_mtlo = 1'b0;
    endtask

    task automatic check_arch(input string tag);
        chk({tag, "_hi"}, hi, ref_hi);
        chk({tag, "_lo"}, lo, ref_lo);
        chk({tag, "_err"}, {31'd0, err}, {31'd0, ref_err});
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while (stall && n < lim) begin
            @(negedge clock);
            n = n + 1;
        end
        chk("idle_wait", {31'd0, stall}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        @(negedge clock);
        #2 reset = 1'b0;
        ref_hi = 32'd0; ref_lo = 32'd0; ref_err = 1'b0;
    endtask

    task automatic do_div(input logic sgn, input logic with_mthi,
                          input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        @(negedge clock);
        op_div = sgn; op_divu = !sgn; op_mthi = with_mthi;
        op_mtlo = 1'($urandom_range(0, 1));
        rs_val = a; rt_val = b;
        if (b == 32'd0) begin
            ref_hi = a; ref_lo = 32'hFFFF_FFFF;
            done_q.push_back('{ref_hi, ref_lo});
            #1 chk("dz_stall", {31'd0, stall}, 32'd0);
            @(negedge clock);
            clear_ops();
        end else begin
            if (sgn) begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end else begin
                q = a / b;
                r = a % b;
            end
            start_q.push_back('{!sgn, a, b, cyc + 1});
            if (hang) begin
                stall_q.push_back(50);
                ref_err = 1'b1;
            end else begin
                stall_q.push_back(35);
                ref_hi = r; ref_lo = q;
                done_q.push_back('{r, q});
            end
            @(negedge clock);
            clear_ops();
            // Strobes while busy must be dropped
            for (int i = 0; i < 18; i++) begin
                @(negedge clock);
                op_div  = 1'($urandom_range(0, 1));
                op_divu = 1'($urandom_range(0, 1));
                op_mthi = 1'($urandom_range(0, 1));
                op_mtlo = 1'($urandom_range(0, 1));
                rs_val = $urandom; rt_val = $urandom;
            end
            @(negedge clock);
            clear_ops();
            wait_idle(120);
        end
        check_arch("div");
    endtask

    task automatic do_mv(input logic to_hi, input logic [31:0] a);
        @(negedge clock);
        op_mthi = to_hi;
        op_mtlo = to_hi ? 1'($urandom_range(0, 1)) : 1'b1;
        rs_val = a; rt_val = $urandom;
        #1 chk("mv_stall", {31'd0, stall}, 32'd0);
        @(negedge clock);
        clear_ops();
        if (to_hi) ref_hi = a; else ref_lo = a;
        check_arch("mv");
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin : stim
        logic [31:0] a, b;
        int          k;
        #1;
        chk("rst0_hi", hi, 32'd0);
        chk("rst0_lo", lo, 32'd0);
        chk("rst0_dvd", div_dividend, 32'd0);
        chk("rst0_dvs", div_divisor, 32'd0);
        chk("rst0_starts", {30'd0, div_start, divu_start}, 32'd0);
        chk("rst0_done", {31'd0, done}, 32'd0);
        chk("rst0_err", {31'd0, err}, 32'd0);
        chk("rst0_stall", {31'd0, stall}, 32'd0);
        @(negedge clock);
        #2 reset = 1'b0;

        // Directed cases
        do_div(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2);
        chk("d028_lo", lo, 32'hFFFF_FFFD);
        chk("d028_hi", hi, 32'hFFFF_FFFF);
        do_div(1'b0, 1'b0, 32'hFFFF_FFF9, 32'd2);
        chk("d029_lo", lo, 32'h7FFF_FFFC);
        chk("d029_hi", hi, 32'd1);
        do_div(1'b1, 1'b0, 32'd5, 32'd0);
        chk("d030_lo", lo, 32'hFFFF_FFFF);
        chk("d030_hi", hi, 32'd5);
        do_mv(1'b1, 32'h1234);
        do_mv(1'b0, 32'hABCD);
        chk("d031_hi", hi, 32'h1234);
        chk("d031_lo", lo, 32'hABCD);
        do_div(1'b1, 1'b1, 32'd100, 32'd7);

        // Reset during WAIT cycle 10 aborts the divide
        @(negedge clock);
        op_div = 1'b1; rs_val = 32'd1000; rt_val = 32'd3;
        start_q.push_back('{1'b0, 32'd1000, 32'd3, cyc + 1});
        @(negedge clock);
        clear_ops();
        repeat (10) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        chk("abort_stall", {31'd0, stall}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        @(negedge clock);
        chk("abort_done", {31'd0, done}, 32'd0);
        #2 reset = 1'b0;
        ref_hi = 32'd0; ref_lo = 32'd0; ref_err = 1'b0;
        do_div(1'b1, 1'b0, 32'hFFFF_FF00, 32'd16);

        // Divider that never finishes
        do_mv(1'b1, 32'hCAFE_0001);
        do_mv(1'b0, 32'hCAFE_0002);
        hang = 1'b1;
        do_div(1'b0, 1'b0, 32'd77, 32'd5);
        @(negedge clock);
        chk("wd_err_sticky", {31'd0, err}, 32'd1);
        hang = 1'b0;
        do_reset();

        // Random mix
        for (int i = 0; i < 30; i++) begin
            k = $urandom_range(0, 5);
            a = $urandom;
            b = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 300)) : $urandom;
            if (k == 5) b = 32'd0;
            if (b == 32'd0 && k < 2) b = 32'd3;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd9;
            case (k)
                0:       do_div(1'b1, 1'($urandom_range(0, 1)), a, b);
                1:       do_div(1'b0, 1'($urandom_range(0, 1)), a, b);
                2:       do_mv(1'b1, a);
                3:       do_mv(1'b0, a);
                default: do_div(1'($urandom_range(0, 1)), 1'b0, a, 32'd0);
            endcase
        end

        repeat (3) @(negedge clock);
        chk("left_done", done_q.size(), 32'd0);
        chk("left_start", start_q.size(), 32'd0);
        chk("left_stall", stall_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
